// File: rtl/req_arbiter4.sv
// rtl/req_arbiter4.sv - four-request arbiter with sticky pending bits and a registered one-hot grant
// Round-robin or fixed-priority selection from the registered pending set, valid/ready handoff.
module req_arbiter4 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant_onehot,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  input  logic       grant_ready,
  output logic [3:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  pending_q;
  logic [3:0]  pending_d;
  logic [1:0]  ptr_q;
  logic [3:0]  onehot_q;
  logic [1:0]  idx_q;
  logic        valid_q;

  logic        accept;
  logic [3:0]  clr;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  base;
  logic [1:0]  cand;

  assign accept = (state_q == GRANT) && grant_ready;
  assign clr    = accept ? onehot_q : 4'b0000;

  // A request arriving on the accept edge re-queues the same index.
  assign pending_d = (pending_q & ~clr) | req;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    base      = (FIXED_PRIO != 0) ? 2'd0 : ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = base + 2'(k);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      ptr_q     <= 2'd0;
      onehot_q  <= 4'b0000;
      idx_q     <= 2'd0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            onehot_q <= 4'b0001 << win_idx;
            idx_q    <= win_idx;
            valid_q  <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            onehot_q <= 4'b0000;
            idx_q    <= 2'd0;
            valid_q  <= 1'b0;
            ptr_q    <= idx_q + 2'd1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_onehot = onehot_q;
  assign grant_idx    = idx_q;
  assign grant_valid  = valid_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// tb/tb_req_arbiter4.sv - directed checks of req_arbiter4 in round-robin and fixed-priority builds
module tb_req_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] rr_req, fp_req;
  logic       rr_ready, fp_ready;
  logic [3:0] rr_onehot, fp_onehot;
  logic [1:0] rr_idx, fp_idx;
  logic       rr_valid, fp_valid;
  logic [3:0] rr_pend, fp_pend;

  int vectors;
  int miscompares;

  req_arbiter4 #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(rr_req),
    .grant_onehot(rr_onehot), .grant_idx(rr_idx), .grant_valid(rr_valid),
    .grant_ready(rr_ready), .pending(rr_pend)
  );

  req_arbiter4 #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(fp_req),
    .grant_onehot(fp_onehot), .grant_idx(fp_idx), .grant_valid(fp_valid),
    .grant_ready(fp_ready), .pending(fp_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rr_req = 4'b0000; fp_req = 4'b0000;
    rr_ready = 1'b0; fp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rr_onehot, rr_idx, rr_valid, rr_pend, fp_onehot, fp_idx, fp_valid, fp_pend} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_state: rr=%b/%b/%b/%b fp=%b/%b/%b/%b required all zero",
               rr_onehot, rr_idx, rr_valid, rr_pend, fp_onehot, fp_idx, fp_valid, fp_pend);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({rr_onehot, rr_idx, rr_valid, rr_pend, fp_onehot, fp_idx, fp_valid, fp_pend} !== 22'd0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: rr=%b/%b/%b/%b fp=%b/%b/%b/%b required all zero", c,
                 rr_onehot, rr_idx, rr_valid, rr_pend, fp_onehot, fp_idx, fp_valid, fp_pend);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    rr_ready = 1'b1;
    rr_req = 4'b0100;
    tick();
    rr_req = 4'b0000;
    vectors++;
    if (rr_pend !== 4'b0100 || rr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_sample: pending=%b valid=%b required 0100/0", rr_pend, rr_valid);
    end
    tick();
    vectors++;
    if (rr_valid !== 1'b1 || rr_onehot !== 4'b0100 || rr_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL single_grant: valid=%b onehot=%b idx=%b required 1/0100/10", rr_valid, rr_onehot, rr_idx);
    end
    tick();
    vectors++;
    if (rr_valid !== 1'b0 || rr_onehot !== 4'b0000 || rr_idx !== 2'd0 || rr_pend !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_drop: valid=%b onehot=%b idx=%b pending=%b required 0/0000/00/0000",
               rr_valid, rr_onehot, rr_idx, rr_pend);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [6];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001; exp_seq[5] = 4'b1000;
    do_reset();
    rr_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin
        rr_req = 4'b1111; tick(); rr_req = 4'b0000;
      end else if (n == 4) begin
        rr_req = 4'b1001; tick(); rr_req = 4'b0000;
      end
      tick();
      vectors++;
      if (rr_valid !== 1'b1 || rr_onehot !== exp_seq[n] || (4'b0001 << rr_idx) !== exp_seq[n]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: valid=%b onehot=%b idx=%0d required 1/%b", n, rr_valid, rr_onehot, rr_idx, exp_seq[n]);
      end
      tick();
      vectors++;
      if (rr_valid !== 1'b0 || rr_onehot !== 4'b0000) begin
        miscompares++;
        $display("FAIL rr_gap%0d: valid=%b onehot=%b required 0/0000", n, rr_valid, rr_onehot);
      end
    end
    vectors++;
    if (rr_pend !== 4'b0000) begin
      miscompares++;
      $display("FAIL rr_drained: pending=%b required 0000", rr_pend);
    end
  endtask

  task automatic test_fixed_blocked();
    logic [3:0] exp_seq [2];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b1000;
    do_reset();
    fp_ready = 1'b0;
    fp_req = 4'b1010;
    tick();
    fp_req = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      fp_req = (c == 3) ? 4'b0001 : 4'b0000;
      tick();
      vectors++;
      if (fp_valid !== 1'b1 || fp_onehot !== 4'b0010 || fp_idx !== 2'd1) begin
        miscompares++;
        $display("FAIL fp_hold%0d: valid=%b onehot=%b idx=%b required 1/0010/01", c, fp_valid, fp_onehot, fp_idx);
      end
    end
    fp_req = 4'b0000;
    vectors++;
    if (fp_pend !== 4'b1011) begin
      miscompares++;
      $display("FAIL fp_pending_blocked: pending=%b required 1011", fp_pend);
    end
    fp_ready = 1'b1;
    tick();
    vectors++;
    if (fp_valid !== 1'b0 || fp_pend !== 4'b1001) begin
      miscompares++;
      $display("FAIL fp_accept: valid=%b pending=%b required 0/1001", fp_valid, fp_pend);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      vectors++;
      if (fp_valid !== 1'b1 || fp_onehot !== exp_seq[n]) begin
        miscompares++;
        $display("FAIL fp_grant%0d: valid=%b onehot=%b required 1/%b", n, fp_valid, fp_onehot, exp_seq[n]);
      end
      tick();
    end
    vectors++;
    if (fp_valid !== 1'b0 || fp_pend !== 4'b0000) begin
      miscompares++;
      $display("FAIL fp_drained: valid=%b pending=%b required 0/0000", fp_valid, fp_pend);
    end
  endtask

  task automatic test_set_clear();
    logic exp_valid;
    do_reset();
    rr_ready = 1'b1;
    rr_req = 4'b0100;
    tick();
    exp_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if (rr_pend[2] !== 1'b1 || rr_valid !== exp_valid || rr_onehot !== (exp_valid ? 4'b0100 : 4'b0000)) begin
        miscompares++;
        $display("FAIL setclr%0d: pending=%b valid=%b onehot=%b required pending[2]=1 valid=%b",
                 c, rr_pend, rr_valid, rr_onehot, exp_valid);
      end
      exp_valid = ~exp_valid;
    end
    rr_req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rr_ready = 1'b1;
    rr_req = 4'b0001;
    tick();
    rr_req = 4'b0000;
    tick();
    tick();
    rr_ready = 1'b0;
    rr_req = 4'b1100;
    tick();
    rr_req = 4'b0000;
    tick();
    vectors++;
    if (rr_valid !== 1'b1 || rr_onehot !== 4'b0100 || rr_pend !== 4'b1100) begin
      miscompares++;
      $display("FAIL mid_setup: valid=%b onehot=%b pending=%b required 1/0100/1100", rr_valid, rr_onehot, rr_pend);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({rr_onehot, rr_idx, rr_valid, rr_pend} !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset: onehot=%b idx=%b valid=%b pending=%b required all zero",
               rr_onehot, rr_idx, rr_valid, rr_pend);
    end
    tick();
    rst_n = 1'b1;
    rr_ready = 1'b1;
    rr_req = 4'b0011;
    tick();
    rr_req = 4'b0000;
    tick();
    vectors++;
    if (rr_valid !== 1'b1 || rr_onehot !== 4'b0001 || rr_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL post_reset_ptr: valid=%b onehot=%b idx=%b required 1/0001/00", rr_valid, rr_onehot, rr_idx);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    rr_req = 4'b0000; fp_req = 4'b0000;
    rr_ready = 1'b0; fp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_blocked();
    test_set_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
